// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge: splits 32-bit iomem accesses into two timed 16-bit sdram controller slots (low half, then high half).
// Define SDRAM_BRIDGE_SKIP_EN to skip a half whose write strobes are all zero.
module sdram_word_bridge #(
  parameter int SLOT_CYCLES = 8,
  parameter int ADDR_BITS   = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [3:0]           wstrb,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] sd_addr,
  output logic                 sd_we,
  output logic                 sd_oe,
  output logic [1:0]           sd_be,
  output logic [15:0]          sd_din,
  input  logic [15:0]          sd_dout
);
  localparam int CW = $clog2(SLOT_CYCLES);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-3:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 wr_q, wr_d, ready_q, ready_d;
  logic                 last, act, half;
  logic                 unused_ok;
  assign unused_ok = ^{addr[31:ADDR_BITS], addr[1:0]};
  always_comb begin
    last    = cnt_q == CW'(SLOT_CYCLES - 1);
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: if (sel) begin
        addr_d  = addr[ADDR_BITS-1:2];
        wdata_d = wdata;
        wstrb_d = wstrb;
        wr_d    = |wstrb;
        cnt_d   = '0;
        state_d = LO;
`ifdef SDRAM_BRIDGE_SKIP_EN
        if (|wstrb && wstrb[1:0] == 2'b00) state_d = HI;
`endif
      end
      LO: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          if (!wr_q) rdata_d[15:0] = sd_dout;
          state_d = HI;
`ifdef SDRAM_BRIDGE_SKIP_EN
          if (wr_q && wstrb_q[3:2] == 2'b00) begin
            state_d = DONE;
            ready_d = 1'b1;
          end
`endif
        end
      end
      HI: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          if (!wr_q) rdata_d[31:16] = sd_dout;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end
  // slot outputs are decoded from registered state only, so sel never reaches sd_*
  assign act     = state_q == LO || state_q == HI;
  assign half    = state_q == HI;
  assign sd_we   = act & wr_q;
  assign sd_oe   = act & ~wr_q;
  assign sd_be   = !act ? 2'b00 : !wr_q ? 2'b11 : half ? wstrb_q[3:2] : wstrb_q[1:0];
  assign sd_din  = !act ? 16'h0 : half ? wdata_q[31:16] : wdata_q[15:0];
  assign sd_addr = act ? {addr_q, half, 1'b0} : '0;
  assign busy    = state_q != IDLE;
  assign ready   = ready_q;
  assign rdata   = rdata_q;
endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb_sdram_word_bridge: directed self-checking bench for sdram_word_bridge at default parameters.
module tb_sdram_word_bridge;
  logic        clk = 1'b0, reset, sel, ready, busy, sd_we, sd_oe;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;
  logic [23:0] sd_addr;
  logic [1:0]  sd_be;
  logic [15:0] sd_din, sd_dout, dout_lo, dout_hi;
  int checks = 0, errors = 0;
  int lat, pulses, oe_cnt, we_cnt;
  logic [23:0] a_lo, a_hi;
  logic [1:0]  be_lo, be_hi;
  logic [15:0] din_lo, din_hi;
  sdram_word_bridge dut (
    .clk(clk), .reset(reset), .sel(sel), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .busy(busy), .sd_addr(sd_addr), .sd_we(sd_we),
    .sd_oe(sd_oe), .sd_be(sd_be), .sd_din(sd_din), .sd_dout(sd_dout)
  );
  always #5 clk = ~clk;
  assign sd_dout = sd_addr[1] ? dout_hi : dout_lo;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // issues one access from IDLE and observes 20 cycles; n counts cycles after the sampling edge
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int drop_at);
    addr = a; wstrb = s; wdata = d; sel = 1'b1;
    lat = 0; pulses = 0; oe_cnt = 0; we_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == drop_at) sel = 1'b0;
      if (n == 1) begin a_lo = sd_addr; be_lo = sd_be; din_lo = sd_din; end
      if (n == 9) begin a_hi = sd_addr; be_hi = sd_be; din_hi = sd_din; end
      if (ready) begin pulses++; if (lat == 0) lat = n; end
      oe_cnt += int'(sd_oe);
      we_cnt += int'(sd_we);
    end
  endtask
  initial begin
    reset = 1'b1; sel = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    dout_lo = 16'h0; dout_hi = 16'h0;
    step(); step();
    chk("rst_outs", {ready, busy, sd_we, sd_oe, sd_be, 26'(0)}, 32'h0);
    chk("rst_addr", {8'h0, sd_addr}, 32'h0);
    chk("rst_din_rdata", {16'h0, sd_din} | rdata, 32'h0);
    reset = 1'b0;
    step();
    dout_lo = 16'hBEEF; dout_hi = 16'hDEAD;
    access(32'h2000_0010, 4'b0000, 32'h0, 1);
    chk("t1_addr_lo", {8'h0, a_lo}, 32'h10);
    chk("t1_addr_hi", {8'h0, a_hi}, 32'h12);
    chk("t1_be", {28'h0, be_lo, be_hi}, 32'hF);
    chk("t1_lat", lat, 17);
    chk("t1_pulses", pulses, 1);
    chk("t1_oe_we", {oe_cnt[15:0], we_cnt[15:0]}, {16'd16, 16'd0});
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_idle", {31'h0, busy}, 32'h0);
    access(32'h2000_0020, 4'b1111, 32'h1234_5678, 1);
    chk("t2_din", {din_hi, din_lo}, 32'h1234_5678);
    chk("t2_be", {28'h0, be_lo, be_hi}, 32'hF);
    chk("t2_oe_we", {oe_cnt[15:0], we_cnt[15:0]}, {16'd0, 16'd16});
    chk("t2_lat", lat, 17);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    access(32'h0000_0104, 4'b0100, 32'hAABB_CCDD, 1);
`ifdef SDRAM_BRIDGE_SKIP_EN
    chk("t3_lat", lat, 9);
    chk("t3_first_addr", {8'h0, a_lo}, 32'h106);
    chk("t3_first_be", {30'h0, be_lo}, 32'h1);
    chk("t3_we", we_cnt, 8);
`else
    chk("t3_lat", lat, 17);
    chk("t3_be", {28'h0, be_lo, be_hi}, 32'h1);
    chk("t3_we", we_cnt, 16);
    chk("t3_din", {din_hi, din_lo}, 32'hAABB_CCDD);
`endif
    chk("t3_pulses", pulses, 1);
    chk("t3_rdata", rdata, 32'hDEADBEEF);
    dout_lo = 16'h1111; dout_hi = 16'h2222;
    access(32'hFF00_0107, 4'b0000, 32'h0, 1);
    chk("addr_mask_lo", {8'h0, a_lo}, 32'h104);
    chk("addr_mask_hi", {8'h0, a_hi}, 32'h106);
    chk("addr_mask_rdata", rdata, 32'h2222_1111);
    dout_lo = 16'h0BAD; dout_hi = 16'hF00D;
    access(32'h0000_0040, 4'b0000, 32'h0, 3);
    chk("t5_lat", lat, 17);
    chk("t5_addr", {a_hi[11:0], a_lo[11:0], 8'h0}, {12'h042, 12'h040, 8'h0});
    chk("t5_oe", oe_cnt, 16);
    chk("t5_rdata", rdata, 32'hF00D_0BAD);
    dout_lo = 16'h5555; dout_hi = 16'h6666;
    access(32'h0000_0080, 4'b0000, 32'h0, 99);
    chk("t4_lat", lat, 17);
    chk("t4_pulses", pulses, 1);
    chk("t4_restart_busy", {31'h0, busy}, 32'h1);
    sel = 1'b0;
    lat = 0; pulses = 0;
    for (int m = 1; m <= 30; m++) begin
      step();
      if (ready) begin pulses++; if (lat == 0) lat = m; end
    end
    chk("t4_second_lat", lat, 15);
    chk("t4_second_pulses", pulses, 1);
    chk("t4_rdata", rdata, 32'h6666_5555);
    addr = 32'h0000_0200; wstrb = 4'b1111; wdata = 32'hCAFE_F00D; sel = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      if (n == 1) sel = 1'b0;
    end
    chk("t6_we_before", {31'h0, sd_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_abort", {29'h0, sd_we, busy, ready}, 32'h0);
    step();
    reset = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      pulses += int'(ready);
    end
    chk("t6_no_ready", pulses, 0);
    dout_lo = 16'h7777; dout_hi = 16'h8888;
    access(32'h0000_0300, 4'b0000, 32'h0, 1);
    chk("t6_next_lat", lat, 17);
    chk("t6_next_rdata", rdata, 32'h8888_7777);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
